// File: rtl/horner_poly_pipe.sv
// Fully pipelined Horner-form polynomial evaluator in Q16 fixed point with
// runtime coefficients, odd/dense modes, valid/ready flow control and saturation.
module horner_poly_pipe #(
    parameter int                         DATA_WIDTH = 16,
    parameter int                         DEGREE     = 3,
    parameter logic signed [31:0]         CUTOFF_Q16 = 32'sd111411,
    parameter logic [(DEGREE+1)*32-1:0]   COEF_INIT  = {32'sd8385, -32'sd80774, 32'sd350157, -32'sd317475},
    localparam int                        AW         = (DEGREE + 1 > 1) ? $clog2(DEGREE + 1) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_r,
    input  logic                  in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [31:0]    out_y,
    output logic                  out_clip,
    output logic                  out_sat,
    input  logic                  cfg_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [31:0]           cfg_data,
    output logic                  cfg_err,
    output logic                  busy
);

    // Handshake: a sample moves on a clock edge when valid & ready are both high;
    // the whole pipeline advances together whenever the output slot is free or popped.

    // Returns {sat, value}: rounded Q16 product clamped to 32 bits.
    function automatic logic [32:0] qmul(input logic signed [31:0] a, input logic signed [31:0] b);
        logic signed [63:0] ae;
        logic signed [63:0] be;
        logic signed [63:0] p;
        logic signed [63:0] t;
        ae = a;
        be = b;
        p  = ae * be;
        t  = (p + 64'sd32768) >>> 16;
        if (t > 64'sd2147483647)
            qmul = {1'b1, 32'h7FFF_FFFF};
        else if (t < -64'sd2147483648)
            qmul = {1'b1, 32'h8000_0000};
        else
            qmul = {1'b0, t[31:0]};
    endfunction

    // Returns {sat, value}: 33-bit sum clamped to 32 bits.
    function automatic logic [32:0] sadd(input logic signed [31:0] a, input logic signed [31:0] b);
        logic [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s[32] != s[31])
            sadd = {1'b1, (s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
        else
            sadd = {1'b0, s[31:0]};
    endfunction

    logic signed [31:0] coef [0:DEGREE];

    logic [DEGREE:0]    s_valid;
    logic [DEGREE:0]    s_gt;
    logic [DEGREE:0]    s_sat;
    logic signed [31:0] s_acc  [0:DEGREE];
    logic [DEGREE-1:0]  s_mode;
    logic signed [31:0] s_r    [0:DEGREE-1];
    logic signed [31:0] s_r2   [0:DEGREE-1];

    logic signed [31:0] nxt_acc [1:DEGREE];
    logic [DEGREE:1]    nxt_sat;

    logic               advance;
    logic               cfg_ok;
    logic               busy_nxt;
    logic signed [31:0] r_ext;
    logic [32:0]        r2_m;
    logic               r_gt;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign r_ext = {{(32-DATA_WIDTH){1'b0}}, in_r};
    assign r2_m  = qmul(r_ext, r_ext);
    assign r_gt  = $unsigned(r_ext) > $unsigned(CUTOFF_Q16);

    // Writes only land while no sample can observe a half-updated coefficient set.
    assign cfg_ok = cfg_we && !busy && !in_valid && (32'(cfg_addr) <= 32'(DEGREE));

    assign busy_nxt = advance ? (|{s_valid[DEGREE-1:0], in_valid}) : (|s_valid);

    always_comb begin
        logic signed [31:0] xo;
        logic [32:0]        m;
        logic [32:0]        a;
        xo = '0;
        m  = '0;
        a  = '0;
        for (int k = 1; k <= DEGREE; k++) begin
            // Odd form uses r^2 for every step but the last, which multiplies by r.
            xo = (s_mode[k-1] || k == DEGREE) ? s_r[k-1] : s_r2[k-1];
            m  = qmul(s_acc[k-1], xo);
            a  = sadd(m[31:0], coef[DEGREE-k]);
            nxt_acc[k] = a[31:0];
            nxt_sat[k] = s_sat[k-1] | m[32] | a[32];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= DEGREE; k++) begin
                coef[k]  <= COEF_INIT[32*k +: 32];
                s_acc[k] <= '0;
            end
            for (int k = 0; k < DEGREE; k++) begin
                s_r[k]  <= '0;
                s_r2[k] <= '0;
            end
            s_valid   <= '0;
            s_gt      <= '0;
            s_sat     <= '0;
            s_mode    <= '0;
            out_valid <= 1'b0;
            out_y     <= '0;
            out_clip  <= 1'b0;
            out_sat   <= 1'b0;
            cfg_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (cfg_ok)
                coef[cfg_addr] <= cfg_data;
            cfg_err <= cfg_we && !cfg_ok;
            busy    <= busy_nxt;
            if (advance) begin
                s_valid[0] <= in_valid;
                s_gt[0]    <= r_gt;
                s_sat[0]   <= r2_m[32];
                s_acc[0]   <= coef[DEGREE];
                s_mode[0]  <= in_mode;
                s_r[0]     <= r_ext;
                s_r2[0]    <= r2_m[31:0];
                for (int k = 1; k <= DEGREE; k++) begin
                    s_valid[k] <= s_valid[k-1];
                    s_gt[k]    <= s_gt[k-1];
                    s_sat[k]   <= nxt_sat[k];
                    s_acc[k]   <= nxt_acc[k];
                end
                for (int k = 1; k < DEGREE; k++) begin
                    s_mode[k] <= s_mode[k-1];
                    s_r[k]    <= s_r[k-1];
                    s_r2[k]   <= s_r2[k-1];
                end
                out_valid <= s_valid[DEGREE];
                out_y     <= s_gt[DEGREE] ? 32'sd0 : s_acc[DEGREE];
                out_clip  <= s_gt[DEGREE];
                out_sat   <= s_sat[DEGREE] & ~s_gt[DEGREE];
            end
        end
    end

endmodule

// File: tb/tb_horner_poly_pipe.sv
// Directed bench for horner_poly_pipe: hand-computed Q16 results, stall/backpressure,
// coefficient writes and mid-stream reset.
module tb_horner_poly_pipe;
    localparam int DW = 24;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [DW-1:0]       in_r;
    logic                in_mode;
    logic                out_valid;
    logic                out_ready;
    logic signed [31:0]  out_y;
    logic                out_clip;
    logic                out_sat;
    logic                cfg_we;
    logic [1:0]          cfg_addr;
    logic [31:0]         cfg_data;
    logic                cfg_err;
    logic                busy;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    horner_poly_pipe #(.DATA_WIDTH(DW), .DEGREE(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_clip(out_clip), .out_sat(out_sat),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic wait_out(output logic signed [31:0] y, output logic clip,
                            output logic sat, output int lat);
        lat = -1; y = '0; clip = 1'b0; sat = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i; y = out_y; clip = out_clip; sat = out_sat;
                break;
            end
        end
    endtask

    task automatic send_one(input logic [DW-1:0] r, input logic mode,
                            output logic signed [31:0] y, output logic clip,
                            output logic sat, output int lat);
        in_valid = 1'b1; in_r = r; in_mode = mode;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(y, clip, sat, lat);
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_r = '0; in_mode = 1'b0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_y !== 32'sd0) begin failures++; $display("FAIL reset_out_y got=%0d exp=0", out_y); end
        checks++; if ({out_clip, out_sat, cfg_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {out_clip, out_sat, cfg_err}); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_modes;
        logic signed [31:0] y; logic c, s; int lat;
        send_one(24'h010000, 1'b0, y, c, s, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL latency got=%0d exp=4", lat); end
        checks++; if (y !== -32'sd39707) begin failures++; $display("FAIL odd_r1 got=%0d exp=-39707", y); end
        checks++; if ({c, s} !== 2'b00) begin failures++; $display("FAIL odd_r1_flags got=%b exp=00", {c, s}); end
        send_one(24'h010000, 1'b1, y, c, s, lat);
        checks++; if (y !== -32'sd39707 || lat !== 4) begin failures++; $display("FAIL dense_r1 got=%0d lat=%0d exp=-39707 lat=4", y, lat); end
    endtask

    task automatic test_values;
        logic signed [31:0] y; logic c, s; int lat;
        in_valid = 1'b1; in_r = 24'd98304; in_mode = 1'b0;
        @(posedge clk); #1;
        in_r = 24'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(y, c, s, lat);
        checks++; if (y !== -32'sd1179 || lat !== 3) begin failures++; $display("FAIL odd_r1p5 got=%0d lat=%0d exp=-1179 lat=3", y, lat); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_y !== -32'sd317475) begin failures++; $display("FAIL odd_r0 got=%0d valid=%b exp=-317475 valid=1", out_y, out_valid); end
    endtask

    task automatic test_clip;
        logic signed [31:0] y; logic c, s; int lat;
        send_one(24'd131072, 1'b0, y, c, s, lat);
        checks++; if (y !== 32'sd0 || c !== 1'b1 || s !== 1'b0) begin failures++; $display("FAIL clip_r2 got=%0d clip=%b sat=%b exp=0 clip=1 sat=0", y, c, s); end
        send_one(24'd111412, 1'b0, y, c, s, lat);
        checks++; if (c !== 1'b1 || y !== 32'sd0) begin failures++; $display("FAIL clip_above got=%0d clip=%b exp=0 clip=1", y, c); end
        send_one(24'd111411, 1'b0, y, c, s, lat);
        checks++; if (c !== 1'b0 || s !== 1'b0) begin failures++; $display("FAIL clip_at_cutoff got clip=%b sat=%b exp clip=0 sat=0", c, s); end
    endtask

    task automatic test_cfg_sat;
        logic signed [31:0] y; logic c, s; int lat;
        repeat (2) begin @(posedge clk); #1; end
        cfg_we = 1'b1; cfg_addr = 2'd3; cfg_data = 32'h7FFF_FFFF;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_idle_err got=%b exp=0", cfg_err); end
        send_one(24'd98304, 1'b0, y, c, s, lat);
        checks++; if (y !== 32'sd2147166172 || s !== 1'b1 || c !== 1'b0) begin failures++; $display("FAIL sat_chain got=%0d sat=%b clip=%b exp=2147166172 sat=1 clip=0", y, s, c); end
        repeat (2) begin @(posedge clk); #1; end
        cfg_we = 1'b1; cfg_addr = 2'd3; cfg_data = 32'd8385;
        @(posedge clk); #1;
        // write colliding with an incoming sample must be dropped
        in_valid = 1'b1; in_r = 24'h010000; in_mode = 1'b0;
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 32'd0;
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_we = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_drop_err got=%b exp=1", cfg_err); end
        @(posedge clk); #1;
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_err_pulse got=%b exp=0", cfg_err); end
        wait_out(y, c, s, lat);
        checks++; if (y !== -32'sd39707 || lat !== 3) begin failures++; $display("FAIL cfg_dropped_result got=%0d lat=%0d exp=-39707 lat=3", y, lat); end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0]      vr [6] = '{24'h010000, 24'd98304, 24'd0, 24'd131072, 24'h010000, 24'd0};
        logic               vm [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic signed [31:0] ve [6] = '{-32'sd39707, -32'sd1179, -32'sd317475, 32'sd0, -32'sd39707, -32'sd317475};
        int sent = 0;
        int pops = 0;
        repeat (2) begin @(posedge clk); #1; end
        exp_q.delete();
        for (int cyc = 0; cyc < 60 && pops < 6; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 9);
            cfg_we = (cyc == 5); cfg_addr = 2'd0; cfg_data = 32'd0;
            in_valid = (sent < 6);
            if (sent < 6) begin in_r = vr[sent]; in_mode = vm[sent]; end
            #1;
            if (out_valid && !out_ready) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL stall_hold cyc=%0d got=%0d exp=none", cyc, out_y); end
                else if (out_y !== exp_q[0]) begin failures++; $display("FAIL stall_hold cyc=%0d got=%0d exp=%0d", cyc, out_y, $signed(exp_q[0])); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL stream_extra cyc=%0d got=%0d exp=none", cyc, out_y); end
                else begin
                    if (out_y !== exp_q[0]) begin failures++; $display("FAIL stream_order pop=%0d got=%0d exp=%0d", pops, out_y, $signed(exp_q[0])); end
                    void'(exp_q.pop_front());
                end
                pops++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ve[sent]);
                sent++;
            end
            if (cyc == 6) begin
                checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL stream_cfg_err got=%b exp=1", cfg_err); end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
        checks++; if (pops !== 6 || sent !== 6 || exp_q.size() !== 0) begin failures++; $display("FAIL stream_count got pops=%0d sent=%0d left=%0d exp 6/6/0", pops, sent, exp_q.size()); end
    endtask

    task automatic test_reset_midstream;
        logic signed [31:0] y; logic c, s; int lat;
        int stray = 0;
        repeat (3) begin @(posedge clk); #1; end
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 32'd0;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        send_one(24'h010000, 1'b0, y, c, s, lat);
        checks++; if (y !== 32'sd277768) begin failures++; $display("FAIL cfg_write_applied got=%0d exp=277768", y); end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_r = 24'h010000; in_mode = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL midreset_state got busy=%b valid=%b ready=%b exp 0/0/1", busy, out_valid, in_ready); end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) stray++;
        end
        checks++; if (stray !== 0) begin failures++; $display("FAIL midreset_stray got=%0d exp=0", stray); end
        send_one(24'h010000, 1'b0, y, c, s, lat);
        checks++; if (y !== -32'sd39707 || lat !== 4) begin failures++; $display("FAIL midreset_coef got=%0d lat=%0d exp=-39707 lat=4", y, lat); end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_values();
        test_clip();
        test_cfg_sat();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/horner_poly_pipe.md
# horner_poly_pipe

Parametrised, fully pipelined Horner-form polynomial evaluator in Q16 fixed point. It is the next generation of the team's fixed-degree cubic covariance kernel. It adds the following over that kernel:
- configurable degree and input width
- runtime-programmable coefficients
- odd/dense evaluation modes
- valid/ready flow control
- saturating arithmetic with status flags

It sits between the distance unit and the covariance-matrix accumulator, with one sample accepted per cycle when not stalled.

## Interface
- DATA_WIDTH, 16: width of the unsigned Q16 input `r`. Legal range 16..24.
- DEGREE, 3: number of Horner steps. Coefficients c[0]..c[DEGREE] are used. Minimum 1.
- CUTOFF_Q16, 32'sd111411: samples with r > CUTOFF_Q16 produce 0.
- COEF_INIT, {8385, -80774, 350157, -317475}: packed (DEGREE+1)×32 signed reset coefficients. c[k] occupies bits [32k+31:32k], so c[DEGREE] is the MSB word.
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample this cycle
- in_r  in  DATA_WIDTH  unsigned Q16 argument
- in_mode  in  1  0 = odd form, 1 = dense form; travels with the sample
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_y  out  32  signed Q16 result
- out_clip  out  1  sample exceeded the cutoff (out_y forced to 0)
- out_sat  out  1  a saturation occurred anywhere on this sample's path
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  clog2(DEGREE+1)  coefficient index
- cfg_data  in  32  signed Q16 coefficient
- cfg_err  out  1  one-cycle pulse: write dropped
- busy  out  1  any pipeline stage holds a valid sample

## Operation
- Q16 multiply uses a full signed 64-bit product, then (p + 2^15) >>> 16, then saturation to [-2^31, 2^31-1]. Add is a 33-bit sum saturated to 32 bits. Any clamp sets the sample's sat bit.
- Stage 0: register r (zero-extended to 32 bits), r2 = qmul(r, r), mode, valid, gt = (r > CUTOFF_Q16) as an unsigned compare.
- Stage k = 1..DEGREE: acc_k = sat(qmul(acc_{k-1}, x_k) + c[DEGREE-k]), with acc_0 = c[DEGREE].
- Operand x_k:
  - mode 0: x_k = r2 for k < DEGREE and x_DEGREE = r, giving y = r·Q(r²) + c[0].
  - mode 1: x_k = r for all k, giving dense P(r).
- Output register: out_y = gt ? 0 : acc_DEGREE. out_clip = gt. out_sat = OR of sat bits; it is forced to 0 when gt.
- Every stage carries valid, mode, gt, sat, r and r2 alongside acc.
- Flow control:
  - advance = !out_valid | out_ready.
  - When advance is 0, all stages hold.
  - in_ready = advance (combinational).
  - A sample is accepted when in_valid & in_ready. Bubbles propagate as valid = 0.
- Coefficient write:
  - Accepted only when busy = 0 and in_valid = 0. It takes effect on the next clock edge.
  - Otherwise the write is dropped, the coefficients are unchanged, and cfg_err pulses high for one cycle.
  - cfg_addr > DEGREE is also dropped with cfg_err.
- Reset (synchronous, any time, including mid-stream):
  - All valid bits and outputs clear. out_valid = 0, out_y = 0, out_clip = 0, out_sat = 0, cfg_err = 0, busy = 0.
  - Coefficients reload to COEF_INIT.
  - In-flight samples are discarded. in_ready reads 1 in the first cycle after reset.

## Timing
- Latency is DEGREE+1 cycles from the accept edge to out_valid. With DEGREE = 3, a sample accepted at edge t has out_valid = 1 after edge t+4.
- Throughput is 1 sample/clk when out_ready is held high.
- out_valid/out_y stay stable while out_valid & !out_ready.
- Simultaneous output pop and input accept in the same cycle is legal and loses nothing.
- busy is registered and reflects the stage valid bits after each edge.

## Test plan
- Defaults, mode 0, r = 0x10000 (1.0), out_ready = 1 → out_valid 4 cycles later, out_y = -39707, clip = 0, sat = 0. The same input in mode 1 also gives -39707.
- Mode 0, r = 98304 (1.5) → r2 = 147456, out_y = -1179. Then r = 0 → out_y = -317475 on the following cycle.
- r = 131072 (2.0) > cutoff → out_y = 0, out_clip = 1, out_sat = 0.
- Idle, write cfg_addr = 3, cfg_data = 32'h7FFFFFFF; then r = 1.5 in mode 0 → out_sat = 1 and out_y equals the saturated Horner chain.
- Stream 6 back-to-back samples with out_ready low from cycle 2 to cycle 9:
  - in_ready = 0 while stalled.
  - All 6 results emerge in order with no duplicates or loss.
  - cfg_we during the stream → cfg_err pulse and coefficients unchanged.
- Assert rst for 1 cycle with 3 samples in flight → no out_valid afterwards, busy = 0, coefficients back to COEF_INIT (verify r = 1.0 gives -39707).
